// File: rtl/unidad_riesgos.sv
// Hazard detection and stall controller for the ID stage: load-use and branch-operand
// stalls, data-memory freeze with timeout, and saturating bubble/freeze counters.
module unidad_riesgos #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RsId,
    input  logic [4:0]       RtId,
    input  logic             UsaRtId,
    input  logic             BranchId,
    input  logic             SaltoTomado,
    input  logic [4:0]       RdEx,
    input  logic             EscEx,
    input  logic             LeeMemEx,
    input  logic [4:0]       RdMem,
    input  logic             LeeMemMem,
    input  logic             MemReq,
    input  logic             MemListo,
    output logic             EscPC,
    output logic             EscIFID,
    output logic             BurbujaIDEX,
    output logic             LimpiarIFID,
    output logic             CongelarTodo,
    output logic [CNT_W-1:0] ContBurbujas,
    output logic [CNT_W-1:0] ContCongelado,
    output logic             ErrorMem
);

    typedef enum logic [1:0] {NORMAL, BURBUJA, MEM} estado_t;

    localparam int unsigned         WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]   ESPERA_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]   ESPERA_ULT = WAIT_W'(MEM_TIMEOUT - 1);

    estado_t           estado, estadoSig, estadoEf;
    logic              pendiente, pendienteSig;
    logic [WAIT_W-1:0] contEspera;
    logic              lu, brEx, brMem, memEspera;

    function automatic logic usa(input logic [4:0] r, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic usaRt);
        return (r != 5'd0) && ((r == rs) || (usaRt && (r == rt)));
    endfunction

    assign lu        = LeeMemEx && EscEx && usa(RdEx, RsId, RtId, UsaRtId);
    assign brEx      = BranchId && EscEx && usa(RdEx, RsId, RtId, UsaRtId);
    assign brMem     = BranchId && LeeMemMem && usa(RdMem, RsId, RtId, UsaRtId);
    assign memEspera = MemReq && !MemListo;

    // Leaving MEM behaves as if already in BURBUJA (pending) or NORMAL, in the same cycle.
    assign estadoEf = (estado == MEM) ? (pendiente ? BURBUJA : NORMAL) : estado;

    always_comb begin
        EscPC        = 1'b1;
        EscIFID      = 1'b1;
        BurbujaIDEX  = 1'b0;
        LimpiarIFID  = 1'b0;
        CongelarTodo = 1'b0;
        estadoSig    = NORMAL;
        pendienteSig = 1'b0;
        if (reset) begin
            estadoSig = NORMAL;
        end else if (memEspera) begin
            CongelarTodo = 1'b1;
            EscPC        = 1'b0;
            EscIFID      = 1'b0;
            estadoSig    = MEM;
            pendienteSig = (estadoEf == BURBUJA);
        end else if (estadoEf == BURBUJA) begin
            EscPC       = 1'b0;
            EscIFID     = 1'b0;
            BurbujaIDEX = 1'b1;
        end else if (lu || brEx || brMem) begin
            EscPC       = 1'b0;
            EscIFID     = 1'b0;
            BurbujaIDEX = 1'b1;
            estadoSig   = (BranchId && lu) ? BURBUJA : NORMAL;
        end else begin
            LimpiarIFID = SaltoTomado;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado        <= NORMAL;
            pendiente     <= 1'b0;
            contEspera    <= '0;
            ErrorMem      <= 1'b0;
            ContBurbujas  <= '0;
            ContCongelado <= '0;
        end else begin
            estado    <= estadoSig;
            pendiente <= pendienteSig;
            if (!memEspera)
                contEspera <= '0;
            else if (contEspera != ESPERA_MAX)
                contEspera <= contEspera + 1'b1;
            if (memEspera && (contEspera == ESPERA_ULT))
                ErrorMem <= 1'b1;
            if (BurbujaIDEX && (ContBurbujas != '1))
                ContBurbujas <= ContBurbujas + 1'b1;
            if (CongelarTodo && (ContCongelado != '1))
                ContCongelado <= ContCongelado + 1'b1;
        end
    end

endmodule

// File: doc/unidad_riesgos.md
Name: unidad_riesgos

Overview:
- Hazard detection and stall controller for the 5-stage pipeline. Acts on the decode (ID) stage.
- It is the producer-side counterpart of the EX-stage forwarding unit. It detects hazards that forwarding cannot resolve:
  - load-use;
  - branch operands resolved in ID;
  - data-memory wait states.
- Drives PC/IF-ID write enables, the ID/EX bubble, the IF-ID flush and a pipeline freeze.
- Keeps saturating bubble and freeze counters.

Parameters:
- CNT_W, 16, width of ContBurbujas and ContCongelado.
- MEM_TIMEOUT, 64, consecutive memory wait cycles before ErrorMem sets.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- RsId  input  5  Rs of instruction in ID.
- RtId  input  5  Rt of instruction in ID.
- UsaRtId  input  1  ID instruction reads Rt.
- BranchId  input  1  ID instruction is a branch (compare done in ID).
- SaltoTomado  input  1  branch in ID resolved taken.
- RdEx  input  5  destination register in EX.
- EscEx  input  1  EX instruction writes a register.
- LeeMemEx  input  1  EX instruction is a load.
- RdMem  input  5  destination register in MEM.
- LeeMemMem  input  1  MEM instruction is a load.
- MemReq  input  1  MEM stage data-memory access active.
- MemListo  input  1  data memory ready.
- EscPC  output  1  PC write enable.
- EscIFID  output  1  IF/ID write enable.
- BurbujaIDEX  output  1  load NOP into ID/EX.
- LimpiarIFID  output  1  flush IF/ID.
- CongelarTodo  output  1  hold ID/EX, EX/MEM, MEM/WB.
- ContBurbujas  output  CNT_W  bubble cycles, saturating.
- ContCongelado  output  CNT_W  freeze cycles, saturating.
- ErrorMem  output  1  sticky memory-timeout flag.

Behaviour:
- Helper functions:
  - usa(r) = (r!=0) && ((r==RsId) || (UsaRtId && r==RtId)).
  - lu = LeeMemEx && EscEx && usa(RdEx).
  - brEx = BranchId && EscEx && usa(RdEx).
  - brMem = BranchId && LeeMemMem && usa(RdMem).
  - memEspera = MemReq && !MemListo.
- State machine:
  - States: NORMAL, BURBUJA (one forced extra stall), MEM (waiting on memory).
  - State is registered; outputs are combinational from state and inputs.
- Output priority, highest first:
  1. memEspera (any state):
     - CongelarTodo=1, EscPC=0, EscIFID=0, BurbujaIDEX=0, LimpiarIFID=0.
     - Next state MEM.
     - A BURBUJA pending flag is kept across the freeze.
  2. State BURBUJA:
     - EscPC=0, EscIFID=0, BurbujaIDEX=1.
     - Next state NORMAL.
  3. NORMAL/MEM, with lu or brEx or brMem:
     - EscPC=0, EscIFID=0, BurbujaIDEX=1.
     - If BranchId && LeeMemEx && EscEx && usa(RdEx), next state BURBUJA (2-bubble total); otherwise NORMAL.
  4. Otherwise:
     - EscPC=1, EscIFID=1, BurbujaIDEX=0.
     - LimpiarIFID=SaltoTomado.
     - Next state NORMAL.
- SaltoTomado is ignored whenever a stall, bubble or freeze is asserted. LimpiarIFID is never asserted together with EscIFID=0.
- Register 0 never causes a hazard.
- MEM state exit: the first cycle with memEspera=0.
  - Goes to BURBUJA if the pending flag is set, else NORMAL; hazard rules then apply in that same cycle.
  - The pending flag clears on entry to BURBUJA.
- Wait counter:
  - Counts consecutive memEspera cycles and clears when memEspera=0.
  - When it reaches MEM_TIMEOUT, ErrorMem sets and holds until reset.
  - The freeze continues regardless of ErrorMem.
- Performance counters:
  - ContBurbujas increments on each clock with BurbujaIDEX=1.
  - ContCongelado increments on each clock with CongelarTodo=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset (async, any time, including mid-stall or mid-freeze):
  - state=NORMAL, pending flag=0, wait counter=0, counters=0, ErrorMem=0.
  - While reset is high, outputs are forced to EscPC=1, EscIFID=1, BurbujaIDEX=0, LimpiarIFID=0, CongelarTodo=0.

Test Plan:
1. Load-use:
   - Stimulus: LeeMemEx=1, EscEx=1, RdEx=5, RsId=5.
   - Required: exactly one cycle with EscPC=0, EscIFID=0, BurbujaIDEX=1; ContBurbujas 0->1. With RdEx=0 instead: no stall.
2. Branch after load:
   - Stimulus: BranchId=1, RtId=7, UsaRtId=1, load with RdEx=7 in EX; next cycle present the load in MEM (LeeMemMem=1, RdMem=7).
   - Required: two consecutive bubbles, then normal flow; ContBurbujas=2.
3. Taken branch, no hazard:
   - Stimulus: SaltoTomado=1.
   - Required: LimpiarIFID=1, EscPC=1. With SaltoTomado=1 plus lu=1: LimpiarIFID=0.
4. Memory wait:
   - Stimulus: MemReq=1, MemListo=0 for 3 cycles, overlapping a pending BURBUJA.
   - Required: CongelarTodo=1 for 3 cycles, ContCongelado=3, no bubble during the freeze; one bubble after MemListo=1.
5. Timeout:
   - Stimulus: MemListo=0 for MEM_TIMEOUT cycles.
   - Required: ErrorMem=1 and held after MemListo returns; cleared only by reset.
6. Saturation and reset:
   - Stimulus: CNT_W=4 with 20 bubble cycles; then assert reset mid-freeze.
   - Required: ContBurbujas=15 (saturated). Reset immediately drives EscPC=1, CongelarTodo=0, counters=0, state NORMAL.
